// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader and the fetch stage.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH  = 32;
  localparam int unsigned IMEM_ADDR_W = 5;

  // RV32I addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// word_data is the assembly register merged with the byte being accepted this cycle;
// lanes above the current one are always zero because the register clears on each word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  lane_q;
  logic [31:0] asm_q;

  // Merge the incoming byte into its lane and flag a completed word.
  always_comb begin
    word_data = asm_q;
    unique case (lane_q)
      2'd0: word_data[7:0]   = byte_data;
      2'd1: word_data[15:8]  = byte_data;
      2'd2: word_data[23:16] = byte_data;
      2'd3: word_data[31:24] = byte_data;
      default: word_data = asm_q;
    endcase
    word_valid = byte_en && ((lane_q == 2'd3) || byte_last);
  end

  // Lane counter and assembly register; cleared at load start and after each word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= 2'd0;
      asm_q  <= 32'd0;
    end else if (clear) begin
      lane_q <= 2'd0;
      asm_q  <= 32'd0;
    end else if (byte_en) begin
      lane_q <= lane_q + 2'd1;
      asm_q  <= word_valid ? 32'd0 : word_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream writer and a combinational fetch read port.
// core_hold stalls the fetch stage while a load is in flight.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter logic [31:0] NOP    = NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              core_hold,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr
);

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       mem_q [DEPTH];

  logic              byte_accept;
  logic              start_ok;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word_data;
  logic [ADDR_W-1:0] fetch_idx;
  logic              unused_fetch_bits;

  assign byte_ready  = (state_q == ST_LOAD);
  assign load_busy   = (state_q == ST_LOAD);
  assign load_done   = (state_q == ST_DONE);
  assign core_hold   = load_busy;
  assign load_count  = count_q;

  assign byte_accept = byte_valid && byte_ready;
  assign start_ok    = (state_q == ST_IDLE) && load_start;
  assign last_word   = (wptr_q == ADDR_W'(DEPTH - 1));

  byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (byte_accept),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Load sequencing: word pointer, word count and state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q <= ST_LOAD;
            wptr_q  <= '0;
            count_q <= '0;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            wptr_q  <= wptr_q + 1'b1;
            count_q <= count_q + 1'b1;
            // Full memory ends the load even without byte_last.
            if (byte_last || last_word) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory array; reset refills every entry with NOP so an aborted load leaves no code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= NOP;
      end
    end else if (word_valid) begin
      mem_q[wptr_q] <= word_data;
    end
  end

  // Word-indexed fetch read; masked to NOP while the image is only partially written.
  always_comb begin
    fetch_idx   = fetch_addr[ADDR_W+1:2];
    fetch_instr = load_busy ? NOP : mem_q[fetch_idx];
  end

  assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory read by the fetch stage. Accepts a byte stream from a host or boot link, packs it little-endian into 32-bit words, and writes them sequentially into a 32-entry instruction memory. The same memory is served to fetch through a combinational read port. While a load is in progress, `core_hold` is asserted so the core can gate `PCWrite` and keep the PC frozen.

## Interface
Parameters:
- `DEPTH`, 32, number of 32-bit instruction words.
- `ADDR_W`, 5, word-address width; must equal log2(`DEPTH`).
- `NOP`, 32'h00000013, fill and hold value (RV32I `addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `byte_valid`  in  1  a byte is offered on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_last`  in  1  qualifies the final byte of the image; sampled with `byte_valid`.
- `byte_ready`  out  1  loader can accept a byte.
- `load_busy`  out  1  high in LOAD.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `load_count`  out  ADDR_W+1  number of words written by the current or last load.
- `core_hold`  out  1  stall request to the fetch stage; equals `load_busy`.
- `fetch_addr`  in  32  fetch-stage PC (byte address).
- `fetch_instr`  out  32  instruction at `fetch_addr`.

## Operation
- Byte transfer: a byte moves when `byte_valid && byte_ready`.
- FSM has three states: IDLE, LOAD, DONE.
- **IDLE**
  - `byte_ready` = 0.
  - `load_start` causes a transition to LOAD and clears the word pointer `wptr`, the byte lane `lane`, the assembly register, and `load_count`.
- **LOAD**
  - `byte_ready` = 1.
  - Each accepted byte is placed in assembly lane `lane`: the first byte goes to bits [7:0], the fourth to bits [31:24].
  - `lane` then increments modulo 4.
  - When lane 3 is accepted, or `byte_last` is accepted in any lane, the word is written to `mem[wptr]`.
  - On a `byte_last` word, unfilled upper lanes are written as zero.
  - On each word write, `wptr` and `load_count` increment and the assembly register clears.
  - Transition to DONE after a `byte_last` write, or after the write of word `DEPTH-1`.
  - If the last memory word fills without `byte_last`, any further bytes are not accepted.
- **DONE**
  - `load_done` = 1 for exactly this one cycle.
  - `byte_ready` = 0.
  - Next state is unconditionally IDLE.
- `load_start` in LOAD or DONE is ignored.
- Read port (combinational):
  - `fetch_instr = mem[fetch_addr[ADDR_W+1:2]]`; `fetch_addr[1:0]` is ignored.
  - In LOAD, `fetch_instr` is forced to `NOP` so a core that does not honour `core_hold` executes no partially loaded code.
- Reset
  - All entries of `mem` are set to `NOP`.
  - State returns to IDLE; `wptr`, `lane`, and `load_count` are set to 0.
  - All outputs are 0, except `fetch_instr` = `NOP`.
  - Reset during LOAD aborts the load; words already written are lost, since the whole memory is refilled with `NOP`.

## Timing
- Load start: with `load_start` high in cycle n, LOAD and `byte_ready` are visible in cycle n+1.
- Word write: the word completed in cycle k is written at the end of cycle k. `load_count` and the read data reflect it from cycle k+1.
- Load end: after the final write in cycle k, `load_done` is high in cycle k+1 and IDLE is reached in cycle k+2. `core_hold` drops in cycle k+1.
- Read latency is 0 cycles from `fetch_addr` to `fetch_instr`.
- Minimum load time: 4·W + 2 cycles for W words at one byte per cycle. `byte_valid` gaps simply stall packing.
- `byte_last` with `byte_valid` low is ignored.

## Structure
- Shared package holds:
  - the FSM state encoding (`ST_IDLE`, `ST_LOAD`, `ST_DONE`);
  - `NOP_INSTR`;
  - `IMEM_DEPTH` and `IMEM_ADDR_W`, shared with the fetch stage so both agree on indexing.
- Natural sub-module: `byte_packer`. It holds the lane counter and assembly register and outputs `word_valid` and `word_data`. The top level owns the FSM, the memory array, and the read port.

## Test plan
- Reset check: pulse `reset`, then sweep `fetch_addr` 0..124 in steps of 4 → every `fetch_instr` = 32'h00000013; all handshake outputs are 0.
- Eight-byte load: `load_start`, then bytes 93,00,50,00,13,01,A0,00 with `byte_last` on the eighth → `mem[0]`=32'h00500093, `mem[1]`=32'h00A00113, `load_count`=2, `load_done` pulses 1 cycle after the last byte.
- Partial final word: load 6 bytes 11,22,33,44,55,66 with `byte_last` on 66 → `mem[1]`=32'h00006655, `load_count`=2.
- Full memory: load 128 bytes without `byte_last` → DONE after word 31, `load_count`=32; a 129th `byte_valid` sees `byte_ready`=0.
- Hold behaviour: `byte_valid` toggled every other cycle and `fetch_addr`=0 during LOAD → packing is unaffected; `core_hold`=1 and `fetch_instr`=NOP throughout; the loaded word is visible once IDLE is reached.
- Reset mid-load: after 3 words written, assert `reset` → IDLE, `load_count`=0, all words read NOP. A `load_start` pulse in LOAD is ignored (no counter clear).
